sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPR, default 2: number of sprite channels, 1..8.
REQ-002 SHALL have parameter SPR_W / SPR_H, default 20 / 20: on-screen sprite box in pixels, 1..64.
REQ-003 SHALL have parameter ROM_W, default 160: sprite-sheet row pitch in words.
REQ-004 SHALL have parameters ADDR_W / IDX_W, default 15 / 5: ROM address and palette-index widths.
REQ-005 SHALL have parameter TRANSP_IDX, default 0: palette index treated as transparent.
REQ-006 SHALL have parameter BG_RGB, default 12'h000: colour output when no sprite is opaque.
REQ-007 SHALL have ports vga_clk in 1 (sole clock, rising edge) and reset_n in 1 (asynchronous, active-low).
REQ-008 SHALL have ports DrawX, DrawY in 10: current pixel; and blank in 1: 1 = active video.
REQ-009 SHALL have ports spr_x, spr_y in NUM_SPR*10: top-left corner per sprite, sprite k at bits [10k+9:10k].
REQ-010 SHALL have ports spr_base in NUM_SPR*ADDR_W: sheet base address per sprite (frame select); spr_en in NUM_SPR; spr_flip in NUM_SPR (horizontal mirror).
REQ-011 SHALL have ports rom_addr out NUM_SPR*ADDR_W: one address per channel; rom_q in NUM_SPR*IDX_W: ROM data, valid exactly 1 cycle after rom_addr.
REQ-012 SHALL have ports pal_idx out IDX_W: winning index; pal_rgb in 12: combinational palette result of pal_idx, {R,G,B}.
REQ-013 SHALL have ports red, green, blue out 4 each.
REQ-014 SHALL have ports collide out NUM_SPR: per-sprite collision of the previous frame; frame_tick out 1: one-cycle pulse.

Function
REQ-015 Stage 0 (register, edge E) SHALL, per channel k: u = DrawX-spr_x, v = DrawY-spr_y in 11-bit unsigned; hit_k = spr_en[k] & DrawX>=spr_x & u<SPR_W & DrawY>=spr_y & v<SPR_H.
REQ-016 Stage 0 SHALL use u' = SPR_W-1-u when spr_flip[k]=1, else u' = u.
REQ-017 Stage 0 SHALL register rom_addr_k = (spr_base_k + v*ROM_W + u') mod 2^ADDR_W on hit, and spr_base_k on miss.
REQ-018 Stage 0 SHALL also register hit vector, DrawX, DrawY, blank.
REQ-019 Stage 1 (edge E+1) SHALL form opaque_k = hit_k & (rom_q_k != TRANSP_IDX) and register it with the delayed metadata.
REQ-020 Stage 1 SHALL register pal_idx = rom_q of the lowest-numbered opaque channel (channel 0 = highest priority), and a flag any_opaque.
REQ-021 Stage 2 (edge E+2) SHALL register {red,green,blue} = pal_rgb if any_opaque, BG_RGB otherwise, when delayed blank=1.
REQ-022 Stage 2 SHALL register {red,green,blue} = 0 when delayed blank=0.
REQ-023 Total latency DrawX/DrawY/blank -> RGB SHALL be 3 vga_clk cycles, fully pipelined, one pixel per cycle, no stalls.
REQ-024 Collision: at stage 1, if blank=1 and popcount(opaque)>=2, every opaque bit SHALL be ORed into working register coll_w.
REQ-025 When stage-1 coordinates equal (0,0), that edge SHALL do all of: collide <= coll_w; coll_w <= this pixel's contribution only; frame_tick <= 1.
REQ-026 frame_tick SHALL be 0 on every other edge.
REQ-027 Box tests SHALL not wrap: a sprite with spr_x+SPR_W > 1023 is clipped at X=1023, never reappears at X=0; same for Y.
REQ-028 Per-sprite position, base, enable and flip inputs SHALL be sampled at stage 0 only; mid-frame changes affect subsequent pixels only.

Reset
REQ-029 While reset_n=0, all pipeline registers, rom_addr, pal_idx, red/green/blue, collide, coll_w and frame_tick SHALL be 0, asynchronously.
REQ-030 After reset_n rises, outputs SHALL reflect the first sampled pixel 3 edges later; RGB before then SHALL be 0.

Verification
REQ-031 Sprite 0 at (100,50), base 0, no flip; drive DrawX=105, DrawY=52 -> rom_addr0=325 after 1 edge; RGB = pal_rgb(rom_q0) after 3 edges.
REQ-032 Same pixel with spr_flip[0]=1, SPR_W=20 -> rom_addr0 = 2*160+14 = 334.
REQ-033 Sprites 0 and 1 overlap, both rom_q=3 -> pal_idx from channel 0 on output.
REQ-034 Sprites 0 and 1 overlap with rom_q0=0 (transparent) and rom_q1=7 -> pal_idx=7; coll_w unchanged.
REQ-035 Collision frame: opaque overlap at (10,10), then stage-1 (0,0) -> collide=2'b11 with one-cycle frame_tick; next frame without overlap -> collide=2'b00.
REQ-036 blank=0 during opaque hit -> RGB=0 and no collision recorded.
REQ-037 reset_n pulsed low mid-line -> all outputs 0 immediately.
REQ-038 Wrap check: spr_x=1015, DrawX=3 -> hit=0.

Source files
------------

// File: rtl/sprite_compositor_if.sv
// Sprite-sheet ROM and palette lookup bus between the compositor (master) and its memories (slave).
// One ROM address/data lane per sprite channel; the palette is a combinational lookup of pal_idx.
interface sprite_compositor_if #(
  parameter int unsigned NUM_SPR = 2,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned IDX_W   = 5
);
  logic [NUM_SPR*ADDR_W-1:0] rom_addr;
  logic [NUM_SPR*IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]          pal_idx;
  logic [11:0]               pal_rgb;

  modport master (output rom_addr, output pal_idx, input rom_q, input pal_rgb);
  modport slave  (input rom_addr, input pal_idx, output rom_q, output pal_rgb);
endinterface

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: box test and sheet addressing, priority/transparency resolve,
// palette colour out. Also accumulates per-sprite collisions over a frame.
module sprite_compositor #(
  parameter int unsigned NUM_SPR    = 2,
  parameter int unsigned SPR_W      = 20,
  parameter int unsigned SPR_H      = 20,
  parameter int unsigned ROM_W      = 160,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned TRANSP_IDX = 0,
  parameter logic [11:0] BG_RGB     = 12'h000
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic [NUM_SPR*10-1:0]     spr_x,
  input  logic [NUM_SPR*10-1:0]     spr_y,
  input  logic [NUM_SPR*ADDR_W-1:0] spr_base,
  input  logic [NUM_SPR-1:0]        spr_en,
  input  logic [NUM_SPR-1:0]        spr_flip,
  sprite_compositor_if.master       mem,
  output logic [3:0]                red,
  output logic [3:0]                green,
  output logic [3:0]                blue,
  output logic [NUM_SPR-1:0]        collide,
  output logic                      frame_tick
);

  localparam int unsigned OFS_W = 11;
  localparam int unsigned CNT_W = 4;

  // ---------------- stage 0: box test and sheet address ----------------
  logic [OFS_W-1:0]          u_c  [NUM_SPR];
  logic [OFS_W-1:0]          v_c  [NUM_SPR];
  logic [OFS_W-1:0]          uf_c [NUM_SPR];
  logic [NUM_SPR-1:0]        hit_c;
  logic [NUM_SPR*ADDR_W-1:0] addr_c;

  // Offsets are 11-bit so a sprite past the right/bottom edge never wraps back to 0.
  always_comb begin
    u_c    = '{default: '0};
    v_c    = '{default: '0};
    uf_c   = '{default: '0};
    hit_c  = '0;
    addr_c = '0;
    for (int k = 0; k < NUM_SPR; k++) begin
      u_c[k]  = {1'b0, DrawX} - {1'b0, spr_x[10*k +: 10]};
      v_c[k]  = {1'b0, DrawY} - {1'b0, spr_y[10*k +: 10]};
      uf_c[k] = spr_flip[k] ? (OFS_W'(SPR_W - 1) - u_c[k]) : u_c[k];
      hit_c[k] = spr_en[k]
               & (DrawX >= spr_x[10*k +: 10]) & (u_c[k] < OFS_W'(SPR_W))
               & (DrawY >= spr_y[10*k +: 10]) & (v_c[k] < OFS_W'(SPR_H));
      addr_c[ADDR_W*k +: ADDR_W] = hit_c[k]
        ? ADDR_W'(32'(v_c[k]) * ROM_W + 32'(uf_c[k]) + 32'(spr_base[ADDR_W*k +: ADDR_W]))
        : spr_base[ADDR_W*k +: ADDR_W];
    end
  end

  logic [NUM_SPR-1:0] hit_s0;
  logic [9:0]         x_s0;
  logic [9:0]         y_s0;
  logic               blank_s0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem.rom_addr <= '0;
      hit_s0       <= '0;
      x_s0         <= '0;
      y_s0         <= '0;
      blank_s0     <= 1'b0;
    end else begin
      mem.rom_addr <= addr_c;
      hit_s0       <= hit_c;
      x_s0         <= DrawX;
      y_s0         <= DrawY;
      blank_s0     <= blank;
    end
  end

  // ---------------- stage 1: transparency, priority, collision ----------------
  logic [NUM_SPR-1:0] opaque_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               any_c;
  logic [CNT_W-1:0]   cnt_c;
  logic [NUM_SPR-1:0] contrib_c;
  logic               frame_c;

  // Channel 0 has the highest priority: the first opaque channel found wins.
  always_comb begin
    opaque_c  = '0;
    win_idx_c = '0;
    any_c     = 1'b0;
    cnt_c     = '0;
    for (int k = 0; k < NUM_SPR; k++) begin
      opaque_c[k] = hit_s0[k] & (mem.rom_q[IDX_W*k +: IDX_W] != IDX_W'(TRANSP_IDX));
      cnt_c       = cnt_c + CNT_W'(opaque_c[k]);
      if (opaque_c[k] && !any_c) begin
        win_idx_c = mem.rom_q[IDX_W*k +: IDX_W];
        any_c     = 1'b1;
      end
    end
    contrib_c = (blank_s0 && (cnt_c >= CNT_W'(2))) ? opaque_c : '0;
    frame_c   = (x_s0 == 10'd0) && (y_s0 == 10'd0);
  end

  logic               blank_s1;
  logic               any_s1;
  logic [NUM_SPR-1:0] coll_w;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem.pal_idx <= '0;
      blank_s1    <= 1'b0;
      any_s1      <= 1'b0;
    end else begin
      mem.pal_idx <= win_idx_c;
      blank_s1    <= blank_s0;
      any_s1      <= any_c;
    end
  end

  // Pixel (0,0) closes the previous frame's collision set and seeds the new one.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      collide    <= '0;
      coll_w     <= '0;
      frame_tick <= 1'b0;
    end else if (frame_c) begin
      collide    <= coll_w;
      coll_w     <= contrib_c;
      frame_tick <= 1'b1;
    end else begin
      coll_w     <= coll_w | contrib_c;
      frame_tick <= 1'b0;
    end
  end

  // ---------------- stage 2: colour out ----------------
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      {red, green, blue} <= 12'h000;
    end else if (!blank_s1) begin
      {red, green, blue} <= 12'h000;
    end else begin
      {red, green, blue} <= any_s1 ? mem.pal_rgb : BG_RGB;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: a behavioural model predicts ROM addresses, palette
// index, colour and collision state per pixel; predictions are queued and retired as the pipe drains.
module tb_sprite_compositor;

  localparam int NS = 2;
  localparam int AW = 15;
  localparam int IW = 5;
  localparam int SW = 20;
  localparam int SH = 20;
  localparam int RW = 160;
  localparam logic [11:0] BG = 12'h123;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic [9:0]        DrawX, DrawY;
  logic              blank;
  logic [NS*10-1:0]  spr_x, spr_y;
  logic [NS*AW-1:0]  spr_base;
  logic [NS-1:0]     spr_en, spr_flip;
  logic [3:0]        red, green, blue;
  logic [NS-1:0]     collide;
  logic              frame_tick;

  logic [IW-1:0] rom_mem [NS][1 << AW];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NS-1:0][AW-1:0] addr;
    logic [IW-1:0]         idx;
    logic                  any;
    logic [NS-1:0]         contrib;
    logic                  frame;
    logic [11:0]           rgb;
  } exp_t;

  exp_t          sb[$];
  logic [NS-1:0] m_coll_w;
  logic [NS-1:0] m_collide;

  sprite_compositor_if #(.NUM_SPR(NS), .ADDR_W(AW), .IDX_W(IW)) bus ();

  sprite_compositor #(
    .NUM_SPR(NS), .SPR_W(SW), .SPR_H(SH), .ROM_W(RW),
    .ADDR_W(AW), .IDX_W(IW), .TRANSP_IDX(0), .BG_RGB(BG)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .spr_x(spr_x), .spr_y(spr_y), .spr_base(spr_base),
    .spr_en(spr_en), .spr_flip(spr_flip),
    .mem(bus),
    .red(red), .green(green), .blue(blue),
    .collide(collide), .frame_tick(frame_tick)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [11:0] pal_fn(input logic [IW-1:0] i);
    return 12'({7'd0, i} * 12'd293 + 12'd17);
  endfunction

  for (genvar g = 0; g < NS; g++) begin : g_rom
    assign bus.rom_q[g*IW +: IW] = rom_mem[g][bus.rom_addr[g*AW +: AW]];
  end
  assign bus.pal_rgb = pal_fn(bus.pal_idx);

  task automatic set_spr(input int k, input int x, input int y, input int base,
                         input bit en, input bit flip);
    spr_x[k*10 +: 10]    = 10'(x);
    spr_y[k*10 +: 10]    = 10'(y);
    spr_base[k*AW +: AW] = AW'(base);
    spr_en[k]            = en;
    spr_flip[k]          = flip;
  endtask

  function automatic exp_t model(input int x, input int y, input bit b);
    exp_t e;
    int sx, sy, col, a, base;
    bit hit;
    logic [IW-1:0] q;
    logic [NS-1:0] opq;
    e.any = 1'b0;
    e.idx = '0;
    opq   = '0;
    for (int k = 0; k < NS; k++) begin
      sx   = int'(spr_x[k*10 +: 10]);
      sy   = int'(spr_y[k*10 +: 10]);
      base = int'(spr_base[k*AW +: AW]);
      hit  = spr_en[k] && x >= sx && x < sx + SW && y >= sy && y < sy + SH;
      col  = spr_flip[k] ? (SW - 1 - (x - sx)) : (x - sx);
      a    = hit ? ((base + (y - sy) * RW + col) % (1 << AW)) : base;
      e.addr[k] = AW'(a);
      q = rom_mem[k][AW'(a)];
      opq[k] = hit && (q != '0);
      if (opq[k] && !e.any) begin
        e.any = 1'b1;
        e.idx = q;
      end
    end
    e.contrib = (b && $countones(opq) >= 2) ? opq : '0;
    e.frame   = (x == 0 && y == 0);
    e.rgb     = !b ? 12'h000 : (e.any ? pal_fn(e.idx) : BG);
    return e;
  endfunction

  // One pixel per clock; retires stage-0, stage-1 and stage-2 predictions after the edge.
  task automatic drive(input int x, input int y, input bit b);
    exp_t e, p;
    bit   tick_exp;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    e = model(x, y, b);
    sb.push_back(e);
    @(posedge vga_clk);
    #1;
    for (int k = 0; k < NS; k++) begin
      checks++;
      if (bus.rom_addr[k*AW +: AW] !== e.addr[k]) begin
        errors++;
        $display("FAIL rom_addr%0d px(%0d,%0d) got %0d exp %0d", k, x, y,
                 bus.rom_addr[k*AW +: AW], e.addr[k]);
      end
    end
    if (sb.size() >= 2) begin
      p = sb[sb.size()-2];
      if (p.any) begin
        checks++;
        if (bus.pal_idx !== p.idx) begin
          errors++;
          $display("FAIL pal_idx got %0d exp %0d", bus.pal_idx, p.idx);
        end
      end
      if (p.frame) begin
        m_collide = m_coll_w;
        m_coll_w  = p.contrib;
        tick_exp  = 1'b1;
      end else begin
        m_coll_w  = m_coll_w | p.contrib;
        tick_exp  = 1'b0;
      end
      checks++;
      if (frame_tick !== tick_exp) begin
        errors++;
        $display("FAIL frame_tick got %b exp %b", frame_tick, tick_exp);
      end
    end
    checks++;
    if (collide !== m_collide) begin
      errors++;
      $display("FAIL collide got %b exp %b", collide, m_collide);
    end
    if (sb.size() >= 3) begin
      p = sb.pop_front();
      checks++;
      if ({red, green, blue} !== p.rgb) begin
        errors++;
        $display("FAIL rgb got %h exp %h", {red, green, blue}, p.rgb);
      end
    end else begin
      checks++;
      if ({red, green, blue} !== 12'h000) begin
        errors++;
        $display("FAIL rgb_after_reset got %h exp 000", {red, green, blue});
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    DrawX = '0; DrawY = '0; blank = 1'b0;
    spr_x = '0; spr_y = '0; spr_base = '0; spr_en = '0; spr_flip = '0;
    #12;
    checks++;
    if ({red, green, blue, collide, frame_tick, bus.pal_idx, bus.rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state got rgb=%h col=%b tick=%b idx=%0d addr=%h exp all 0",
               {red, green, blue}, collide, frame_tick, bus.pal_idx, bus.rom_addr);
    end
    sb.delete();
    m_coll_w  = '0;
    m_collide = '0;
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    set_spr(0, 100, 50, 0, 1'b1, 1'b0);
    set_spr(1, 600, 400, 0, 1'b0, 1'b0);
    drive(105, 52, 1'b1);
    checks++;
    if (bus.rom_addr[AW-1:0] !== 15'd325) begin
      errors++;
      $display("FAIL basic_addr got %0d exp 325", bus.rom_addr[AW-1:0]);
    end
    drive(106, 52, 1'b1);
    drive(107, 52, 1'b1);
  endtask

  task automatic test_flip();
    spr_flip[0] = 1'b1;
    drive(105, 52, 1'b1);
    checks++;
    if (bus.rom_addr[AW-1:0] !== 15'd334) begin
      errors++;
      $display("FAIL flip_addr got %0d exp 334", bus.rom_addr[AW-1:0]);
    end
    drive(119, 69, 1'b1);
    spr_flip[0] = 1'b0;
  endtask

  task automatic test_boundary();
    for (int x = 98; x <= 121; x++) drive(x, 52, 1'b1);
    drive(110, 49, 1'b1);
    drive(110, 50, 1'b1);
    drive(110, 69, 1'b1);
    drive(110, 70, 1'b1);
  endtask

  task automatic test_wrap();
    set_spr(0, 0, 0, 0, 1'b0, 1'b0);
    set_spr(1, 1015, 0, 700, 1'b1, 1'b0);
    drive(3, 5, 1'b1);
    checks++;
    if (bus.rom_addr[AW +: AW] !== 15'd700) begin
      errors++;
      $display("FAIL wrap_miss got %0d exp 700", bus.rom_addr[AW +: AW]);
    end
    drive(1015, 5, 1'b1);
    drive(1023, 5, 1'b1);
    drive(1014, 5, 1'b1);
    drive(0, 5, 1'b1);
    set_spr(1, 100, 1015, 700, 1'b1, 1'b0);
    drive(105, 3, 1'b1);
    drive(105, 1023, 1'b1);
  endtask

  task automatic test_priority();
    set_spr(0, 200, 100, 1000, 1'b1, 1'b0);
    set_spr(1, 210, 105, 2000, 1'b1, 1'b0);
    rom_mem[0][2615] = 5'd3; rom_mem[1][2805] = 5'd3;
    rom_mem[0][2616] = 5'd9; rom_mem[1][2806] = 5'd4;
    rom_mem[0][2617] = 5'd0; rom_mem[1][2807] = 5'd7;
    drive(215, 110, 1'b1);
    drive(216, 110, 1'b1);
    drive(217, 110, 1'b1);
    drive(218, 110, 1'b1);
  endtask

  task automatic test_collision();
    set_spr(0, 5, 5, 0, 1'b1, 1'b0);
    set_spr(1, 8, 8, 400, 1'b1, 1'b0);
    rom_mem[0][1127] = 5'd0;
    drive(0, 0, 1'b1);
    drive(12, 12, 1'b1);
    drive(30, 30, 1'b1);
    drive(0, 0, 1'b1);
    drive(1, 0, 1'b1);
    drive(10, 10, 1'b1);
    drive(0, 0, 1'b1);
    drive(1, 0, 1'b1);
    checks++;
    if (collide !== 2'b11 || frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL coll_frame got col=%b tick=%b exp col=11 tick=1", collide, frame_tick);
    end
    drive(40, 40, 1'b1);
    drive(10, 10, 1'b0);
    drive(0, 0, 1'b1);
    drive(1, 0, 1'b1);
    checks++;
    if (collide !== 2'b00) begin
      errors++;
      $display("FAIL coll_clear got %b exp 00", collide);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      if ((i % 10) == 0) begin
        for (int k = 0; k < NS; k++)
          set_spr(k, int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
                  int'($urandom_range(0, 4000)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 15) == 0) drive(0, 0, 1'b1);
      else drive(int'($urandom_range(0, 90)), int'($urandom_range(0, 90)),
                 1'($urandom_range(0, 7) != 0));
    end
  endtask

  task automatic test_mid_reset();
    set_spr(0, 100, 50, 0, 1'b1, 1'b0);
    set_spr(1, 100, 50, 300, 1'b1, 1'b0);
    drive(105, 52, 1'b1);
    drive(0, 0, 1'b1);
    drive(106, 52, 1'b1);
    drive(107, 52, 1'b1);
    reset_n = 1'b0;
    #2;
    checks++;
    if ({red, green, blue, collide, frame_tick, bus.pal_idx, bus.rom_addr} !== '0) begin
      errors++;
      $display("FAIL mid_reset got rgb=%h col=%b tick=%b idx=%0d addr=%h exp all 0",
               {red, green, blue}, collide, frame_tick, bus.pal_idx, bus.rom_addr);
    end
    sb.delete();
    m_coll_w  = '0;
    m_collide = '0;
    @(negedge vga_clk);
    reset_n = 1'b1;
    drive(105, 52, 1'b1);
    drive(106, 52, 1'b1);
    drive(107, 52, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < NS; k++)
      for (int a = 0; a < (1 << AW); a++)
        rom_mem[k][a] = IW'((a * 7 + k * 3) % 31 + 1);
    test_reset();
    test_basic();
    test_flip();
    test_boundary();
    test_wrap();
    test_priority();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    for (int i = 0; i < 3; i++) drive(500, 500, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
